// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: control state encoding and the
// RV32I opcode values the surrounding decode logic cares about.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } fetch_state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC adder: sequential step or taken branch with a sign-extended
// 13-bit byte offset. Arithmetic wraps silently at 2^PC_WIDTH.
module fetch_next_pc #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned PC_INC   = 4
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                branch_op_i,
  input  logic                branch_taken_i,
  input  logic [12:0]         imm_i,
  output logic [PC_WIDTH-1:0] next_pc_o
);

  logic [PC_WIDTH-1:0] offset;

  // Select the step: branch offset only when the decoder flags a branch and the ALU says taken.
  always_comb begin
    offset = PC_WIDTH'(PC_INC);
    if (branch_op_i && branch_taken_i) begin
      offset = PC_WIDTH'($signed(imm_i));
    end
    next_pc_o = pc_i + offset;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/control sequencer feeding the instruction decoder.
// Instruction memory handshake: imem_req_out is held high for the whole
// FETCH state; the transfer completes on the posedge where imem_req_out=1 and
// imem_ack_in=1, and imem_rdata_in is captured on that edge. imem_ack_in seen
// while imem_req_out=0 is ignored.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned         PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
  parameter int unsigned         PC_INC         = 4,
  parameter int unsigned         TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                peripheral_reset_n,
  input  logic                run_in,
  input  logic                halt_in,
  output logic                imem_req_out,
  output logic [PC_WIDTH-1:0] imem_addr_out,
  input  logic                imem_ack_in,
  input  logic [31:0]         imem_rdata_in,
  output logic [31:0]         inst_out,
  output logic                en_inst_decode_out,
  output logic                decode_out,
  output logic                write_back_out,
  input  logic                branch_op_in,
  input  logic                branch_taken_in,
  input  logic [12:0]         immediate_branch_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                busy_out,
  output logic                fault_out,
  output fetch_state_e        state_dbg_out
);

  // Last FETCH count value tolerated before faulting; unused when timeout is disabled.
  localparam logic [31:0] TMO_LIMIT =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, next_pc;
  logic [31:0]         inst_q, inst_d;
  logic [31:0]         tmo_q, tmo_d;
  logic                req_q, req_d;
  logic                en_dec_q, en_dec_d;
  logic                dec_q, dec_d;
  logic                wb_q, wb_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;

  fetch_next_pc #(
    .PC_WIDTH (PC_WIDTH),
    .PC_INC   (PC_INC)
  ) u_next_pc (
    .pc_i           (pc_q),
    .branch_op_i    (branch_op_in),
    .branch_taken_i (branch_taken_in),
    .imm_i          (immediate_branch_in),
    .next_pc_o      (next_pc)
  );

  // Next-state, PC, instruction latch and timeout counter; outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_in) begin
          state_d = ST_FETCH;
          tmo_d   = '0;
        end
      end
      ST_FETCH: begin
        if (imem_ack_in) begin
          inst_d  = imem_rdata_in;
          state_d = ST_DECODE;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LIMIT)) begin
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_DECODE: state_d = ST_READ;
      ST_READ:   state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        pc_d = next_pc;
        if (halt_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
          tmo_d   = '0;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    req_d    = (state_d == ST_FETCH);
    en_dec_d = (state_d == ST_DECODE);
    dec_d    = (state_d == ST_READ);
    wb_d     = (state_d == ST_WB);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    fault_d  = (state_d == ST_FAULT);
  end

  // State and registered outputs; reset aborts everything immediately.
  always_ff @(posedge clock or negedge peripheral_reset_n) begin
    if (!peripheral_reset_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      tmo_q    <= '0;
      req_q    <= 1'b0;
      en_dec_q <= 1'b0;
      dec_q    <= 1'b0;
      wb_q     <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      tmo_q    <= tmo_d;
      req_q    <= req_d;
      en_dec_q <= en_dec_d;
      dec_q    <= dec_d;
      wb_q     <= wb_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign imem_req_out       = req_q;
  assign imem_addr_out      = pc_q;
  assign pc_out             = pc_q;
  assign inst_out           = inst_q;
  assign en_inst_decode_out = en_dec_q;
  assign decode_out         = dec_q;
  assign write_back_out     = wb_q;
  assign busy_out           = busy_q;
  assign fault_out          = fault_q;
  assign state_dbg_out      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: instruction-level reference model (PC arithmetic,
// phase table, expected-instruction queue) driven with randomized stimulus.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_in = 1'b0, halt_in = 1'b0;
  logic        imem_ack_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        branch_op_in = 1'b0, branch_taken_in = 1'b0;
  logic [12:0] immediate_branch_in = '0;
  logic        imem_req_out, en_inst_decode_out, decode_out, write_back_out;
  logic        busy_out, fault_out;
  logic [31:0] imem_addr_out, pc_out, inst_out;
  fetch_state_e state_dbg_out;

  logic [5:0]  outs;
  assign outs = {imem_req_out, en_inst_decode_out, decode_out, write_back_out, busy_out, fault_out};

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clock = ~clock;

  fetch_sequencer dut (
    .clock               (clock),
    .peripheral_reset_n  (rst_n),
    .run_in              (run_in),
    .halt_in             (halt_in),
    .imem_req_out        (imem_req_out),
    .imem_addr_out       (imem_addr_out),
    .imem_ack_in         (imem_ack_in),
    .imem_rdata_in       (imem_rdata_in),
    .inst_out            (inst_out),
    .en_inst_decode_out  (en_inst_decode_out),
    .decode_out          (decode_out),
    .write_back_out      (write_back_out),
    .branch_op_in        (branch_op_in),
    .branch_taken_in     (branch_taken_in),
    .immediate_branch_in (immediate_branch_in),
    .pc_out              (pc_out),
    .busy_out            (busy_out),
    .fault_out           (fault_out),
    .state_dbg_out       (state_dbg_out)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic start_run();
    run_in = 1'b1;
    tick();
    run_in = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle through WB; outputs are
  // checked at each negedge against the phase table (req,en,dec,wb,busy,fault).
  task automatic exec_instr(input int delay, input logic [31:0] word, input logic br_op,
                            input logic br_tk, input logic [12:0] imm, input logic halt);
    logic [31:0] exp_inst;
    for (int d = 0; d <= delay; d++) begin
      n_cmp++;
      if (outs !== 6'b100010 || imem_addr_out !== model_pc || pc_out !== model_pc) begin
        n_err++;
        $display("FAIL fetch_c%0d: got outs=%b addr=%h pc=%h exp outs=100010 addr=%h",
                 d, outs, imem_addr_out, pc_out, model_pc);
      end
      imem_ack_in   = (d == delay);
      imem_rdata_in = (d == delay) ? word : $urandom;
      run_in        = 1'($urandom_range(0, 1));
      halt_in       = 1'($urandom_range(0, 1));
      if (d == delay) exp_q.push_back(word);
      tick();
    end
    exp_inst = exp_q.pop_front();
    // DECODE
    n_cmp++;
    if (outs !== 6'b010010 || inst_out !== exp_inst) begin
      n_err++;
      $display("FAIL decode: got outs=%b inst=%h exp outs=010010 inst=%h", outs, inst_out, exp_inst);
    end
    imem_ack_in = 1'($urandom_range(0, 1)); imem_rdata_in = $urandom;
    tick();
    // READ
    n_cmp++;
    if (outs !== 6'b001010 || inst_out !== exp_inst) begin
      n_err++;
      $display("FAIL read: got outs=%b inst=%h exp outs=001010 inst=%h", outs, inst_out, exp_inst);
    end
    imem_ack_in = 1'($urandom_range(0, 1)); imem_rdata_in = $urandom;
    tick();
    // EXEC
    n_cmp++;
    if (outs !== 6'b000010 || inst_out !== exp_inst) begin
      n_err++;
      $display("FAIL exec: got outs=%b inst=%h exp outs=000010 inst=%h", outs, inst_out, exp_inst);
    end
    tick();
    // WB
    n_cmp++;
    if (outs !== 6'b000110 || inst_out !== exp_inst || pc_out !== model_pc) begin
      n_err++;
      $display("FAIL wb: got outs=%b inst=%h pc=%h exp outs=000110 inst=%h pc=%h",
               outs, inst_out, pc_out, exp_inst, model_pc);
    end
    branch_op_in = br_op; branch_taken_in = br_tk; immediate_branch_in = imm;
    halt_in = halt; run_in = halt ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    if (br_op && br_tk) model_pc = model_pc + {{19{imm[12]}}, imm};
    else                model_pc = model_pc + 32'd4;
    branch_op_in = 1'b0; branch_taken_in = 1'b0; halt_in = 1'b0; run_in = 1'b0; imem_ack_in = 1'b0;
    if (halt) begin
      n_cmp++;
      if (outs !== 6'b000000 || state_dbg_out !== ST_IDLE || pc_out !== model_pc) begin
        n_err++;
        $display("FAIL halt_idle: got outs=%b state=%0d pc=%h exp outs=000000 IDLE pc=%h",
                 outs, state_dbg_out, pc_out, model_pc);
      end
    end
  endtask

  task automatic test_reset();
    imem_ack_in = 1'b1; run_in = 1'b1;
    #2;
    n_cmp++;
    if (outs !== 6'b000000 || pc_out !== 32'h0 || inst_out !== 32'h0 || state_dbg_out !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got outs=%b pc=%h inst=%h exp all zero", outs, pc_out, inst_out);
    end
    @(negedge clock);
    imem_ack_in = 1'b0; run_in = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (outs !== 6'b000000 || state_dbg_out !== ST_IDLE || pc_out !== 32'h0) begin
      n_err++;
      $display("FAIL idle_hold: got outs=%b state=%0d exp idle", outs, state_dbg_out);
    end
    model_pc = 32'h0;
  endtask

  task automatic test_basic();
    start_run();
    exec_instr(0, 32'h00500093, 1'b0, 1'b1, 13'h1FF8, 1'b0);
  endtask

  task automatic test_ack_delay();
    exec_instr(3, $urandom, 1'b0, 1'b0, 13'h0, 1'b0);
    exec_instr(15, $urandom, 1'b0, 1'b0, 13'h0, 1'b0); // ack on the limit cycle wins
  endtask

  task automatic test_branch();
    exec_instr(0, $urandom, 1'b1, 1'b1, 13'(32'h20 - model_pc), 1'b0);
    exec_instr(0, $urandom, 1'b1, 1'b1, 13'h1FF8, 1'b0);   // 0x20 -> 0x18
    exec_instr(1, $urandom, 1'b0, 1'b1, 13'h0100, 1'b0);   // 0x18 -> 0x1C
    exec_instr(0, $urandom, 1'b0, 1'b0, 13'h0, 1'b0);      // 0x1C -> 0x20
    exec_instr(2, $urandom, 1'b1, 1'b0, 13'h1FF8, 1'b0);   // 0x20 -> 0x24
    n_cmp++;
    if (imem_addr_out !== 32'h24) begin
      n_err++;
      $display("FAIL branch_not_taken: got addr=%h exp 00000024", imem_addr_out);
    end
  endtask

  task automatic test_halt();
    exec_instr(1, $urandom, 1'b0, 1'b0, 13'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      imem_ack_in = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if (outs !== 6'b000000 || state_dbg_out !== ST_IDLE || pc_out !== model_pc) begin
        n_err++;
        $display("FAIL idle_wait: got outs=%b pc=%h exp 000000 pc=%h", outs, pc_out, model_pc);
      end
    end
    imem_ack_in = 1'b0;
    start_run();
    exec_instr(0, $urandom, 1'b0, 1'b0, 13'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [12:0] imm;
    logic        halt;
    for (int i = 0; i < 30; i++) begin
      imm  = 13'($urandom_range(0, 8191)) & 13'h1FFE;
      halt = (i != 29) && ($urandom_range(0, 5) == 0);
      exec_instr(int'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), imm, halt);
      if (halt) start_run();
    end
  endtask

  task automatic test_reset_mid_fetch();
    imem_ack_in = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 6'b000000 || pc_out !== 32'h0 || inst_out !== 32'h0 || state_dbg_out !== ST_IDLE) begin
      n_err++;
      $display("FAIL mid_fetch_reset: got outs=%b pc=%h inst=%h exp all zero", outs, pc_out, inst_out);
    end
    @(negedge clock);
    rst_n = 1'b1;
    model_pc = 32'h0;
    exp_q.delete();
    start_run();
    exec_instr(0, $urandom, 1'b0, 1'b0, 13'h0, 1'b0);
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (outs !== 6'b100010) begin
        n_err++;
        $display("FAIL timeout_wait%0d: got outs=%b exp 100010", k, outs);
      end
      imem_ack_in = 1'b0;
      tick();
    end
    n_cmp++;
    if (outs !== 6'b000001 || state_dbg_out !== ST_FAULT) begin
      n_err++;
      $display("FAIL fault_entry: got outs=%b state=%0d exp 000001 FAULT", outs, state_dbg_out);
    end
    run_in = 1'b1; imem_ack_in = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if (outs !== 6'b000001 || state_dbg_out !== ST_FAULT) begin
      n_err++;
      $display("FAIL fault_sticky: got outs=%b exp 000001", outs);
    end
    run_in = 1'b0; imem_ack_in = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    n_cmp++;
    if (outs !== 6'b000000 || pc_out !== 32'h0) begin
      n_err++;
      $display("FAIL fault_cleared: got outs=%b pc=%h exp 000000 pc=0", outs, pc_out);
    end
    model_pc = 32'h0;
    start_run();
    exec_instr(2, $urandom, 1'b0, 1'b0, 13'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_branch();
    test_halt();
    test_back_to_back();
    test_reset_mid_fetch();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
